// File: rtl/mem_arbiter.sv
// Purpose : two-requester (fetch / data) arbiter onto one shared memory port, round-robin on contention.
// Latency : request seen in IDLE -> mem_req next cycle -> done/err registered one cycle after mem_ready/timeout.
// Backpressure: requesters hold req until done/err; memory stalls via mem_ready, bounded by TIMEOUT.
module mem_arbiter #(
  parameter int TIMEOUT = 16  // legal range 1..31, fits the 5-bit wait counter
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  // data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_D  = 2'd2;

  // Abort fires in the BUSY cycle whose stall would take the count to TIMEOUT.
  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [4:0] wait_cnt;
  logic       last_d;       // 1 = most recent grant went to the data requester
  logic       if_elig;
  logic       d_elig;
  logic       busy;
  logic       timeout_hit;
  logic       finish;

  // A requester whose done/err is showing this cycle has not yet had a chance
  // to drop req, so it must not be granted again off the stale request.
  assign if_elig     = if_req && !if_done && !if_err;
  assign d_elig      = d_req  && !d_done  && !d_err;
  assign busy        = (state == S_BUSY_IF) || (state == S_BUSY_D);
  assign timeout_hit = busy && !mem_ready && (wait_cnt == CNT_LAST);
  assign finish      = busy && (mem_ready || timeout_hit);

  // Next-state: arbitrate in IDLE, leave BUSY on completion or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (d_elig && (!if_elig || !last_d)) begin
          state_nxt = S_BUSY_D;
        end else if (if_elig) begin
          state_nxt = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_D: begin
        if (finish) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory port drive: decoded from state only, address/data passed from the granted requester.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state)
      S_BUSY_IF: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
      end
      S_BUSY_D: begin
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // State register and round-robin history; history moves at grant time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      last_d <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_BUSY_D) begin
        last_d <= 1'b1;
      end else if (state == S_IDLE && state_nxt == S_BUSY_IF) begin
        last_d <= 1'b0;
      end
    end
  end

  // Wait counter: zero on BUSY entry, counts stalled BUSY cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 5'd0;
    end else if (!busy || finish) begin
      wait_cnt <= 5'd0;
    end else begin
      wait_cnt <= wait_cnt + 5'd1;
    end
  end

  // Completion pulses: one cycle each; success takes priority over abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_done <= 1'b0;
      if_err  <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      if_done <= (state == S_BUSY_IF) && mem_ready;
      if_err  <= (state == S_BUSY_IF) && timeout_hit;
      d_done  <= (state == S_BUSY_D)  && mem_ready;
      d_err   <= (state == S_BUSY_D)  && timeout_hit;
    end
  end

  // Read data capture: fetches and loads only; stores and aborts leave data untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      if (state == S_BUSY_IF && mem_ready) begin
        if_rdata <= mem_rdata;
      end
      if (state == S_BUSY_D && mem_ready && !d_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (TIMEOUT=4): stimulus pushes expected
// completions and memory accesses; negedge monitors pop and compare.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // completion kinds
  localparam logic [1:0] K_IF_DONE = 2'd0;
  localparam logic [1:0] K_IF_ERR  = 2'd1;
  localparam logic [1:0] K_D_DONE  = 2'd2;
  localparam logic [1:0] K_D_ERR   = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] rdata;
  } cmp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  cmp_t exp_q[$];
  acc_t mem_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: at most one pulse per cycle, each matched to the next expectation.
  always @(negedge clk) begin
    int   n;
    cmp_t e;
    logic [1:0]  k;
    logic [31:0] rd;
    if (mon_en && !reset) begin
      n = int'(if_done) + int'(if_err) + int'(d_done) + int'(d_err);
      check("one_pulse_max", (n > 1) ? 32'd1 : 32'd0, 32'd0);
      if (n >= 1) begin
        k  = if_done ? K_IF_DONE : if_err ? K_IF_ERR : d_done ? K_D_DONE : K_D_ERR;
        rd = (k == K_IF_DONE || k == K_IF_ERR) ? if_rdata : d_rdata;
        if (exp_q.size() == 0) begin
          check("unexpected_completion", {30'd0, k}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("completion_kind", {30'd0, k}, {30'd0, e.kind});
          check("completion_rdata", rd, e.rdata);
        end
      end
    end
  end

  // Memory port monitor: accepted accesses match expectations; idle port drives zeros.
  always @(negedge clk) begin
    acc_t a;
    if (mon_en && !reset) begin
      if (mem_req && mem_ready) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_access", mem_addr, 32'hFFFF_FFFF);
        end else begin
          a = mem_q.pop_front();
          check("mem_we", {31'd0, mem_we}, {31'd0, a.we});
          check("mem_addr", mem_addr, a.addr);
          check("mem_wdata", mem_wdata, a.wdata);
        end
      end else if (!mem_req) begin
        check("idle_port_zero", {mem_we, mem_addr[30:0]} | mem_wdata, 32'd0);
      end
    end
  end

  // One access by one requester; ready asserted on BUSY cycle index 'delay'
  // (delay >= TO means never). Returns the number of BUSY cycles observed.
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int delay, output int busy_cycles);
    bit seen = 0;
    busy_cycles = 0;
    mem_ready = 1'b0;
    mem_rdata = rdata;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int t = 0; t < 60 && !seen; t++) begin
      tick();
      if (is_d ? (d_done | d_err) : (if_done | if_err)) begin
        seen = 1;
      end else if (mem_req) begin
        mem_ready = (busy_cycles == delay);
        busy_cycles++;
      end
    end
    if (!seen) check("access_wait_budget", 32'd0, 32'd1);
    d_req = 1'b0;
    if_req = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    int bc;
    int ncomp;
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 32'h5555_AAAA;
    mem_ready = 1'b1;   // ready while idle must be ignored
    tick(); tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_pulses", {28'd0, if_done, if_err, d_done, d_err}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    mon_en = 1;
    tick(); tick();   // idle cycles with mem_ready high

    // single load
    exp_q.push_back('{K_D_DONE, 32'hDEAD_BEEF});
    mem_q.push_back('{1'b0, 32'h100, 32'h0});
    access(1, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, bc);
    check("load_busy_cycles", bc, 1);

    // store: d_rdata unchanged
    exp_q.push_back('{K_D_DONE, 32'hDEAD_BEEF});
    mem_q.push_back('{1'b1, 32'h40, 32'h1234_5678});
    access(1, 1, 32'h40, 32'h1234_5678, 32'hAAAA_5555, 0, bc);
    check("store_busy_cycles", bc, 1);

    // fetch with two stall cycles
    exp_q.push_back('{K_IF_DONE, 32'hCAFE_F00D});
    mem_q.push_back('{1'b0, 32'h200, 32'h0});
    access(0, 0, 32'h200, 32'h0, 32'hCAFE_F00D, 2, bc);
    check("fetch_busy_cycles", bc, 3);

    // fetch timeout: if_err after 4 BUSY cycles, if_rdata kept
    exp_q.push_back('{K_IF_ERR, 32'hCAFE_F00D});
    access(0, 0, 32'h204, 32'h0, 32'hBAD0_BAD0, 99, bc);
    check("fetch_timeout_cycles", bc, TO);

    // ready exactly on the last allowed cycle: done wins
    exp_q.push_back('{K_D_DONE, 32'h0BAD_CAFE});
    mem_q.push_back('{1'b0, 32'h104, 32'h9});
    access(1, 0, 32'h104, 32'h9, 32'h0BAD_CAFE, TO - 1, bc);
    check("boundary_busy_cycles", bc, TO);

    // data timeout: d_err, d_rdata kept
    exp_q.push_back('{K_D_ERR, 32'h0BAD_CAFE});
    access(1, 0, 32'h108, 32'h0, 32'h1111_2222, 99, bc);
    check("d_timeout_cycles", bc, TO);

    // reset during BUSY_D: no pulse, outputs at reset values
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hFEED_0001;
    mem_ready = 1'b0;
    tick(); tick();
    check("pre_reset_busy", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_pulses", {28'd0, if_done, if_err, d_done, d_err}, 32'd0);
    check("mid_rst_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;

    // contention from reset: D, IF, D, IF with mem_ready always high
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h77;
    mem_ready = 1'b1;
    mem_rdata = 32'h600D_0000;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] rv;
      rv = 32'h600D_0000 + 32'(i);
      if (i % 2 == 0) begin
        exp_q.push_back('{K_D_DONE, rv});
        mem_q.push_back('{1'b0, 32'h300, 32'h77});
      end else begin
        exp_q.push_back('{K_IF_DONE, rv});
        mem_q.push_back('{1'b0, 32'h400, 32'h0});
      end
    end
    tick();
    reset = 1'b0;
    ncomp = 0;
    for (int t = 0; t < 40 && ncomp < 4; t++) begin
      tick();
      if (if_done | d_done | if_err | d_err) begin
        ncomp++;
        mem_rdata = 32'h600D_0000 + 32'(ncomp);
        if (ncomp == 4) begin
          if_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
    check("contention_completions", ncomp, 4);
    mem_ready = 1'b0;
    tick(); tick(); tick();

    check("exp_q_drained", exp_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
